hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 32: cycles from divider start pulse to valid q/r.
REQ-002 SHALL have one clock and a synchronous, active-high reset; clock and reset ports come first.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  divide request.
REQ-006 req_ready  out  1  high only in IDLE.
REQ-007 req_signed  in  1  1=DIV (signed), 0=DIVU.
REQ-008 a  in  32  dividend; b  in  32  divisor.
REQ-009 mthi_we, mtlo_we  in  1 each  direct HI/LO write strobes.
REQ-010 wdata  in  32  data for mthi/mtlo.
REQ-011 hi, lo  out  32 each  architectural HI (remainder) and LO (quotient).
REQ-012 busy  out  1  high from acceptance until HI/LO are written.
REQ-013 div_by_zero  out  1  sticky flag, cleared on the next accepted request.
REQ-014 div_start  out  1  one-cycle start pulse to the external Division unit.
REQ-015 div_a, div_b  out  32 each  unsigned magnitudes sent to the divider.
REQ-016 div_q, div_r  in  32 each  divider quotient and remainder.

Function
REQ-017 SHALL implement states IDLE, START, WAIT, FIX.
REQ-018 Acceptance: req_valid & req_ready at an edge latches a, b and req_signed; a nonzero b moves the FSM to START.
REQ-019 START (1 cycle): div_start=1; div_a=|a| and div_b=|b| if signed, raw values otherwise; the FSM then loads a counter with DIV_LATENCY-1 and enters WAIT.
REQ-020 WAIT: div_a/div_b held stable and div_start=0; the counter decrements each cycle; at 0 the FSM captures div_q/div_r and enters FIX.
REQ-021 FIX (1 cycle): LO=quotient, negated if signed and sign(a)!=sign(b); HI=remainder, negated if signed and a<0; then IDLE.
REQ-022 busy SHALL deassert in the same cycle that hi/lo show the new values; total latency is DIV_LATENCY+2 edges after acceptance.
REQ-023 Signed overflow SHALL be handled by the normal path: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-024 Divide by zero (b==0): the divider is not started; on the next edge HI=a, LO=0xFFFFFFFF, div_by_zero=1, busy 1 cycle.
REQ-025 mthi_we/mtlo_we SHALL write HI/LO only in IDLE; they are ignored while busy.
REQ-026 If req and mt write occur together in IDLE, the mt write SHALL take effect and the request SHALL still be accepted; the division result later overwrites HI/LO.
REQ-027 req_valid while busy SHALL NOT be accepted and SHALL NOT disturb the operation in flight.
REQ-028 Unsigned results SHALL be a plain 32-bit copy of div_q/div_r, with no sign fix.

Reset
REQ-029 Reset SHALL put the FSM in IDLE and set hi=0, lo=0, busy=0, div_start=0, div_by_zero=0, div_a=0, div_b=0, counter=0.
REQ-030 Reset asserted mid-operation SHALL abandon the division; HI/LO return to 0 and the late divider output is ignored.
REQ-031 Reset SHALL take priority over req_valid and mt writes in the same cycle.

Structure
REQ-032 Shared package hilo_pkg SHALL hold the state enum, the DIV_LATENCY default, and the constants DIV0_LO=0xFFFFFFFF and INT_MIN=0x80000000.
REQ-033 The divider SHALL be instantiated outside this block and connected through the div_* ports.
REQ-034 One combinational sub-module, div_sign_fix, SHALL compute magnitudes and the final negation.

Verification
REQ-035 DIVU a=9, b=3 -> after 34 edges LO=3, HI=0, busy low, div_start pulsed exactly once.
REQ-036 DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
REQ-038 DIVU a=5, b=0 -> next edge HI=5, LO=0xFFFFFFFF, div_by_zero=1, no div_start.
REQ-039 During a busy 9/3: mthi_we with wdata=0x1234 and a second req_valid -> both ignored; final HI=0, LO=3; a later idle mtlo_we with wdata=0xAB gives LO=0xAB.
REQ-040 Reset pulsed 10 cycles into a division -> hi=lo=0, busy=0 next edge; a new 8/2 then gives LO=4, HI=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO divide controller.
// The state enum, the default divider latency and the fixed result constants.
package hilo_pkg;

  localparam int unsigned DIV_LATENCY_DEFAULT = 32;
  localparam logic [31:0] DIV0_LO             = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN             = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    FIX   = 2'd3
  } state_e;

  // Two's-complement negate when en is set; INT_MIN maps onto itself.
  function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Request, move-to and result signals between the CPU pipeline and the
// HI/LO divide controller.
interface hilo_div_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        div_by_zero;

  modport master (
    output req_valid, req_signed, a, b, mthi_we, mtlo_we, wdata,
    input  req_ready, hi, lo, busy, div_by_zero
  );

  modport slave (
    input  req_valid, req_signed, a, b, mthi_we, mtlo_we, wdata,
    output req_ready, hi, lo, busy, div_by_zero
  );

endinterface

// File: rtl/div_sign_fix.sv
// Sign handling around an unsigned divider: operand magnitudes going in,
// quotient/remainder negation coming out.
module div_sign_fix
  import hilo_pkg::*;
(
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] quot,
  input  logic [31:0] rem,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic [31:0] quot_fix,
  output logic [31:0] rem_fix
);

  logic a_neg;
  logic b_neg;

  assign a_neg = is_signed & a[31];
  assign b_neg = is_signed & b[31];

  assign mag_a = neg_if(a_neg, a);
  assign mag_b = neg_if(b_neg, b);

  // Quotient takes the XOR of the operand signs, the remainder follows the dividend.
  assign quot_fix = neg_if(a_neg ^ b_neg, quot);
  assign rem_fix  = neg_if(a_neg, rem);

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and sequencer for DIV/DIVU driving an external
// fixed-latency unsigned divider, plus MTHI/MTLO writes while idle.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  hilo_div_ctrl_if.slave     bus,
  output logic               div_start,
  output logic [31:0]        div_a,
  output logic [31:0]        div_b,
  input  logic [31:0]        div_q,
  input  logic [31:0]        div_r
);

  localparam int unsigned       CNT_W    = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        quot_q, quot_d;
  logic [31:0]        rem_q, rem_d;
  logic               dz_pend_q, dz_pend_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               dz_q, dz_d;

  logic [31:0]        quot_fix;
  logic [31:0]        rem_fix;

  // Operands are latched raw; magnitudes are derived from them so div_a/div_b stay stable.
  div_sign_fix u_sign_fix (
    .is_signed (sgn_q),
    .a         (a_q),
    .b         (b_q),
    .quot      (quot_q),
    .rem       (rem_q),
    .mag_a     (div_a),
    .mag_b     (div_b),
    .quot_fix  (quot_fix),
    .rem_fix   (rem_fix)
  );

  always_comb begin
    // NOTE: every *_d takes its hold value first, so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mthi_we) hi_d = bus.wdata;
        if (bus.mtlo_we) lo_d = bus.wdata;
        if (bus.req_valid) begin
          a_d   = bus.a;
          b_d   = bus.b;
          sgn_d = bus.req_signed;
          dz_d  = 1'b0;
          if (bus.b == 32'd0) begin
            // Divide by zero skips the divider and commits through FIX next edge.
            quot_d    = DIV0_LO;
            rem_d     = bus.a;
            dz_pend_d = 1'b1;
            state_d   = FIX;
          end else begin
            dz_pend_d = 1'b0;
            state_d   = START;
          end
        end
      end
      START: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          quot_d  = div_q;
          rem_d   = div_r;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        if (dz_pend_q) begin
          hi_d = rem_q;
          lo_d = quot_q;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with <= only; blocking = stays in the comb block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign div_start       = (state_q == START);
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural fixed-latency divider.
// Vector table plus scoreboard, and hand sequences for busy pokes and reset.
module tb_hilo_div_ctrl;
  import hilo_pkg::*;

  localparam int unsigned LAT = DIV_LATENCY_DEFAULT;

  typedef struct packed {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] div_q = 32'd0;
  logic [31:0] div_r = 32'd0;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];

  hilo_div_ctrl_if bus();

  hilo_div_ctrl #(.DIV_LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_q     (div_q),
    .div_r     (div_r)
  );

  always #5 clock = ~clock;

  // Divider model: garbage until LAT cycles after the start pulse, then a/b and a%b.
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd1;
  int          m_cnt = 0;
  always @(posedge clock) begin
    if (div_start) begin
      m_a   <= div_a;
      m_b   <= div_b;
      m_cnt <= int'(LAT) - 1;
      div_q <= 32'hDEAD_BEEF;
      div_r <= 32'hDEAD_BEEF;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_q <= m_a / m_b;
        div_r <= m_a % m_b;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    if (sgn && v[31]) r = 32'd0 - v;
    return r;
  endfunction

  // Drive one request for one cycle; returns at the negedge after the acceptance edge.
  task automatic start_req(input vec_t v, input bit track);
    @(negedge clock);
    check("req_ready before request", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_signed = v.sgn;
    bus.a          = v.a;
    bus.b          = v.b;
    if (track) exp_q.push_back(v);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  // Count edges until busy drops; optionally poke mthi + a second request at edge poke_at.
  task automatic wait_done(input vec_t v, input int poke_at, output int edges, output int starts);
    edges  = 0;
    starts = 0;
    while (bus.busy === 1'b1 && edges < 200) begin
      if (div_start === 1'b1) begin
        starts++;
        check("div_a magnitude at start", div_a, mag(v.sgn, v.a));
        check("div_b magnitude at start", div_b, mag(v.sgn, v.b));
      end
      if (edges == poke_at) begin
        bus.mthi_we    = 1'b1;
        bus.wdata      = 32'h0000_1234;
        bus.req_valid  = 1'b1;
        bus.req_signed = 1'b0;
        bus.a          = 32'd100;
        bus.b          = 32'd1;
      end
      @(negedge clock);
      bus.mthi_we   = 1'b0;
      bus.req_valid = 1'b0;
      edges++;
    end
    if (edges >= 200) check("busy timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic finish_op(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " hi"}, bus.hi, e.hi);
    check({tag, " lo"}, bus.lo, e.lo);
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dz));
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v93;
    vec_t v82;
    int   edges;
    int   starts;

    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.a          = 32'd0;
    bus.b          = 32'd0;
    bus.mthi_we    = 1'b0;
    bus.mtlo_we    = 1'b0;
    bus.wdata      = 32'd0;

    //           sgn   a              b              hi             lo             dz
    vecs[0] = '{1'b0, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{1'b1, INT_MIN,       32'hFFFF_FFFF, 32'd0,         INT_MIN,       1'b0};
    vecs[3] = '{1'b0, 32'd5,         32'd0,         32'd5,         DIV0_LO,       1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 1'b0};
    vecs[5] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         1'b0};
    vecs[7] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, DIV0_LO,       1'b1};
    vecs[9] = '{1'b0, 32'd8,         32'd2,         32'd0,         32'd4,         1'b0};
    v93     = vecs[0];
    v82     = vecs[9];

    repeat (3) @(negedge clock);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    check("reset div_start", 32'(div_start), 32'd0);
    check("reset div_a", div_a, 32'd0);
    check("reset div_b", div_b, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start_req(vecs[i], 1'b1);
      wait_done(vecs[i], -1, edges, starts);
      check($sformatf("vec%0d latency", i), 32'(edges),
            (vecs[i].b == 32'd0) ? 32'd1 : 32'(LAT + 2));
      check($sformatf("vec%0d start pulses", i), 32'(starts),
            (vecs[i].b == 32'd0) ? 32'd0 : 32'd1);
      finish_op($sformatf("vec%0d", i));
    end

    // mthi and a second request while busy are both ignored.
    start_req(v93, 1'b1);
    wait_done(v93, 5, edges, starts);
    check("busy poke latency", 32'(edges), 32'(LAT + 2));
    check("busy poke start pulses", 32'(starts), 32'd1);
    finish_op("busy poke");
    @(negedge clock);
    check("no second op accepted", 32'(bus.busy), 32'd0);
    bus.mtlo_we = 1'b1;
    bus.wdata   = 32'h0000_00AB;
    @(negedge clock);
    bus.mtlo_we = 1'b0;
    check("idle mtlo lo", bus.lo, 32'h0000_00AB);
    check("idle mtlo hi untouched", bus.hi, 32'd0);

    // mthi together with an accepted request: write lands, result overwrites later.
    @(negedge clock);
    bus.mthi_we    = 1'b1;
    bus.wdata      = 32'h0000_0055;
    bus.req_valid  = 1'b1;
    bus.req_signed = v93.sgn;
    bus.a          = v93.a;
    bus.b          = v93.b;
    exp_q.push_back(v93);
    @(negedge clock);
    bus.mthi_we   = 1'b0;
    bus.req_valid = 1'b0;
    check("mt+req hi written", bus.hi, 32'h0000_0055);
    check("mt+req accepted", 32'(bus.busy), 32'd1);
    wait_done(v93, -1, edges, starts);
    check("mt+req latency", 32'(edges), 32'(LAT + 2));
    finish_op("mt+req");

    // Reset 10 cycles into a division abandons it.
    @(negedge clock);
    bus.mthi_we = 1'b1;
    bus.wdata   = 32'h0000_0077;
    @(negedge clock);
    bus.mthi_we = 1'b0;
    check("pre-reset hi", bus.hi, 32'h0000_0077);
    start_req(v93, 1'b0);
    repeat (10) @(negedge clock);
    check("mid-op busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid-op reset hi", bus.hi, 32'd0);
    check("mid-op reset lo", bus.lo, 32'd0);
    check("mid-op reset busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clock);
    check("late divider ignored hi", bus.hi, 32'd0);
    check("late divider ignored lo", bus.lo, 32'd0);
    check("late divider ignored busy", 32'(bus.busy), 32'd0);
    start_req(v82, 1'b1);
    wait_done(v82, -1, edges, starts);
    check("post-reset latency", 32'(edges), 32'(LAT + 2));
    finish_op("post-reset 8/2");

    // Reset wins over a request and an mthi write in the same cycle.
    @(negedge clock);
    reset          = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_signed = 1'b0;
    bus.a          = 32'd9;
    bus.b          = 32'd3;
    bus.mthi_we    = 1'b1;
    bus.wdata      = 32'h0000_0099;
    @(negedge clock);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.mthi_we   = 1'b0;
    check("reset priority busy", 32'(bus.busy), 32'd0);
    check("reset priority hi", bus.hi, 32'd0);
    check("reset priority lo", bus.lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
